prio_q_sr: RTL

- Parametrised successor of the 5-level heap priority queue used by the PDES event scheduler. It is a systolic sorted-register queue of DEPTH entries, each holding a {key, payload} pair.
- Supports single-cycle enqueue, dequeue, and simultaneous enqueue+dequeue (replace), even when full.
- Keeps FIFO order among equal keys. Provides full/empty flags and sticky error flags.
- Sits between the event-generation cores and the LP dispatch stage. The head entry is always the minimum timestamp.

---
 rtl/prio_q_pkg.sv | 23 ++
 rtl/prio_q_sr_if.sv | 40 ++++
 rtl/pq_cell.sv | 69 ++++++
 rtl/prio_q_sr.sv | 122 ++++++++++++
 4 files changed

// File: rtl/prio_q_pkg.sv
// Shared definitions for the priority-queue family: default widths,
// the entry record layout and the ceil-log2 helper used for derived widths.
package prio_q_pkg;

    localparam int DEF_KW    = 16;
    localparam int DEF_PW    = 16;
    localparam int DEF_DEPTH = 32;

    typedef struct packed {
        logic              valid;
        logic [DEF_KW-1:0] key;
        logic [DEF_PW-1:0] data;
    } entry_t;

    // Smallest r with 2**r >= n; clogb2(DEPTH+1) sizes a 0..DEPTH counter.
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/prio_q_sr_if.sv
// Request/status bundle of the sorted-register priority queue.
// Handshake: an enqueue is taken on a posedge where enq && enq_ready; a dequeue
// is taken where deq && !empty; flush overrides both in the same cycle.
interface prio_q_sr_if
    import prio_q_pkg::*;
#(
    parameter int KW    = DEF_KW,
    parameter int PW    = DEF_PW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = clogb2(DEPTH + 1)
);
    logic          enq;
    logic [KW-1:0] enq_key;
    logic [PW-1:0] enq_data;
    logic          enq_ready;
    logic          deq;
    logic          flush;
    logic [KW-1:0] out_key;
    logic [PW-1:0] out_data;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          err_ovf;
    logic          err_udf;
    logic          clr_err;

    modport master (
        output enq, enq_key, enq_data, deq, flush, clr_err,
        input  enq_ready, out_key, out_data, out_valid, count, full, empty,
               err_ovf, err_udf
    );

    modport slave (
        input  enq, enq_key, enq_data, deq, flush, clr_err,
        output enq_ready, out_key, out_data, out_valid, count, full, empty,
               err_ovf, err_udf
    );

endinterface

// File: rtl/pq_cell.sv
// One slot of the systolic sorted queue. le_* flags say whether a slot is
// valid with key <= enq_key; being monotonic, they locate the insert point p.
module pq_cell #(
    parameter int KW      = 16,
    parameter int PW      = 16,
    parameter bit IS_HEAD = 1'b0
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          enq_op,
    input  logic          deq_op,
    input  logic          le_self,
    input  logic          le_left,
    input  logic          le_right,
    input  logic          left_valid,
    input  logic [KW-1:0] left_key,
    input  logic [PW-1:0] left_data,
    input  logic          right_valid,
    input  logic [KW-1:0] right_key,
    input  logic [PW-1:0] right_data,
    input  logic [KW-1:0] new_key,
    input  logic [PW-1:0] new_data,
    output logic          q_valid,
    output logic [KW-1:0] q_key,
    output logic [PW-1:0] q_data
);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_key   <= '0;
            q_data  <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (enq_op && deq_op) begin
            // Replace: slots 0..p-1 (at least the head) shift down by one and
            // the new entry lands where the right neighbour no longer sorts before it.
            if (IS_HEAD || le_self) begin
                if (le_right) begin
                    q_valid <= right_valid;
                    q_key   <= right_key;
                    q_data  <= right_data;
                end else begin
                    q_valid <= 1'b1;
                    q_key   <= new_key;
                    q_data  <= new_data;
                end
            end
        end else if (enq_op) begin
            if (!le_self) begin
                if (le_left) begin
                    q_valid <= 1'b1;
                    q_key   <= new_key;
                    q_data  <= new_data;
                end else begin
                    q_valid <= left_valid;
                    q_key   <= left_key;
                    q_data  <= left_data;
                end
            end
        end else if (deq_op) begin
            q_valid <= right_valid;
            q_key   <= right_key;
            q_data  <= right_data;
        end
    end

endmodule

// File: rtl/prio_q_sr.sv
// Systolic sorted-register priority queue: head is always the minimum key,
// equal keys leave in arrival order; supports enqueue, dequeue and replace.
module prio_q_sr
    import prio_q_pkg::*;
#(
    parameter int KW    = DEF_KW,
    parameter int PW    = DEF_PW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic        CLK,
    input  logic        rst_n,
    prio_q_sr_if.slave  bus
);

    localparam int CW = clogb2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] le;
    logic [KW-1:0]    k [DEPTH];
    logic [PW-1:0]    d [DEPTH];
    logic [CW-1:0]    cnt;
    logic             enq_acc;
    logic             deq_acc;
    logic             enq_op;
    logic             deq_op;
    logic             ovf_evt;
    logic             udf_evt;

    assign bus.full      = (cnt == CW'(DEPTH));
    assign bus.empty     = (cnt == '0);
    assign bus.enq_ready = !bus.full || (bus.deq && !bus.empty);
    assign enq_acc       = bus.enq && bus.enq_ready;
    assign deq_acc       = bus.deq && !bus.empty;
    assign enq_op        = enq_acc && !bus.flush;
    assign deq_op        = deq_acc && !bus.flush;
    assign ovf_evt       = !bus.flush && bus.enq && !bus.enq_ready;
    assign udf_evt       = !bus.flush && bus.deq && bus.empty;

    assign bus.count     = cnt;
    assign bus.out_valid = v[0];
    assign bus.out_key   = v[0] ? k[0] : '0;
    assign bus.out_data  = v[0] ? d[0] : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic          l_v, r_v, l_le, r_le;
        logic [KW-1:0] l_k, r_k;
        logic [PW-1:0] l_d, r_d;

        // Invalid slots must never win a compare, so the valid bit gates it.
        assign le[i] = v[i] && (k[i] <= bus.enq_key);

        if (i == 0) begin : g_left_edge
            assign l_v  = 1'b0;
            assign l_k  = '0;
            assign l_d  = '0;
            assign l_le = 1'b1;
        end else begin : g_left
            assign l_v  = v[i-1];
            assign l_k  = k[i-1];
            assign l_d  = d[i-1];
            assign l_le = le[i-1];
        end

        if (i == DEPTH - 1) begin : g_right_edge
            assign r_v  = 1'b0;
            assign r_k  = '0;
            assign r_d  = '0;
            assign r_le = 1'b0;
        end else begin : g_right
            assign r_v  = v[i+1];
            assign r_k  = k[i+1];
            assign r_d  = d[i+1];
            assign r_le = le[i+1];
        end

        pq_cell #(.KW(KW), .PW(PW), .IS_HEAD(i == 0)) u_cell (
            .CLK         (CLK),
            .rst_n       (rst_n),
            .flush       (bus.flush),
            .enq_op      (enq_op),
            .deq_op      (deq_op),
            .le_self     (le[i]),
            .le_left     (l_le),
            .le_right    (r_le),
            .left_valid  (l_v),
            .left_key    (l_k),
            .left_data   (l_d),
            .right_valid (r_v),
            .right_key   (r_k),
            .right_data  (r_d),
            .new_key     (bus.enq_key),
            .new_data    (bus.enq_data),
            .q_valid     (v[i]),
            .q_key       (k[i]),
            .q_data      (d[i])
        );
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (enq_acc && !deq_acc) begin
            cnt <= cnt + CW'(1);
        end else if (deq_acc && !enq_acc) begin
            cnt <= cnt - CW'(1);
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_ovf <= 1'b0;
            bus.err_udf <= 1'b0;
        end else begin
            bus.err_ovf <= ovf_evt || (bus.err_ovf && !bus.clr_err);
            bus.err_udf <= udf_evt || (bus.err_udf && !bus.clr_err);
        end
    end

endmodule
